sdram_burst_tester: RTL and testbench
=====================================

SDRAM_BURST_TESTER -- requirements
Module: sdram_burst_tester

Interface
REQ-001 The module SHALL have parameter BURST, default 8, meaning words per burst (1..512), driven onto sdram_wr_burst/sdram_rd_burst.
REQ-002 The module SHALL have parameter NUM_BURSTS, default 4, meaning bursts per write phase and per read phase (1..65535).
REQ-003 The module SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles to wait for an ack after req rises.
REQ-004 clk  in  1  sole clock (same as sdram_controller clk, 100 MHz); all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a test run.
REQ-007 seed  in  16  pattern seed, captured at start.
REQ-008 base_addr  in  24  first word address, captured at start.
REQ-009 sdram_init_done  in  1  controller initialisation complete.
REQ-010 sdram_wr_req  out  1  write request to controller.
REQ-011 sdram_wr_ack  in  1  write acknowledge; one word consumed per high cycle.
REQ-012 sdram_wr_addr  out  24  burst start address.
REQ-013 sdram_wr_burst  out  10  constant BURST.
REQ-014 sdram_din  out  16  write data.
REQ-015 sdram_rd_req  out  1  read request to controller.
REQ-016 sdram_rd_ack  in  1  read acknowledge; sdram_dout valid in every high cycle.
REQ-017 sdram_rd_addr  out  24  burst start address.
REQ-018 sdram_rd_burst  out  10  constant BURST.
REQ-019 sdram_dout  in  16  read data.
REQ-020 busy  out  1  run in progress.
REQ-021 done  out  1  one-cycle pulse at run end.
REQ-022 pass  out  1  last run had err_cnt==0 and no timeout; held until next start.
REQ-023 timeout  out  1  last run aborted on ack timeout; held until next start.
REQ-024 err_cnt  out  16  mismatching words in last run, saturating at 16'hFFFF.
REQ-025 first_err_addr  out  24  address of first mismatch, 0 if none.

Function
REQ-026 The state machine SHALL use states IDLE, WAIT_INIT, WR_REQ, WR_DATA, RD_REQ, RD_DATA, FINISH.
REQ-027 IDLE: on start, the module SHALL capture seed and base_addr, clear err_cnt/first_err_addr/pass/timeout, set busy, and go to WAIT_INIT; start SHALL be ignored in every other state.
REQ-028 WAIT_INIT: the module SHALL hold until sdram_init_done=1, then go to WR_REQ with burst index b=0.
REQ-029 Address of word k of burst b SHALL be (base_addr + b*BURST + k) mod 2^24; the req address SHALL be word 0 of the burst.
REQ-030 Pattern for address A SHALL be A[15:0] ^ seed ^ {A[23:16],A[23:16]}.
REQ-031 WR_REQ: sdram_wr_req SHALL be 1, and sdram_din SHALL present the word-0 pattern; on the first cycle with sdram_wr_ack=1, the module SHALL drop req next cycle and enter WR_DATA.
REQ-032 sdram_din SHALL always present the pattern of the word indexed by the write word counter; the counter SHALL increment on each wr_ack cycle, covering the ack cycle seen in WR_REQ.
REQ-033 WR_DATA: after BURST ack cycles, the module SHALL go to WR_REQ with b+1, or to RD_REQ with b=0 after burst NUM_BURSTS-1.
REQ-034 Ack cycles beyond BURST within one burst SHALL be ignored and SHALL NOT advance the counter.
REQ-035 RD_REQ/RD_DATA SHALL mirror REQ-031..034 with rd_req/rd_ack; in each counted rd_ack cycle, sdram_dout SHALL be compared with the expected pattern.
REQ-036 On a read mismatch, err_cnt SHALL increment (saturating), and on the first mismatch first_err_addr SHALL take that word address.
REQ-037 After the last read burst, the module SHALL go to FINISH, pulse done for one cycle, set pass=(err_cnt==0), clear busy, and return to IDLE.
REQ-038 If no ack arrives within TIMEOUT cycles of req rising, the module SHALL drop req, set timeout=1 and pass=0, and go to FINISH.
REQ-039 wr_req and rd_req SHALL never be high in the same cycle; reqs SHALL be registered outputs.
REQ-040 If sdram_init_done falls mid-run, the run SHALL continue; only WAIT_INIT qualifies on it.

Reset
REQ-041 On rst=1, asynchronously: state IDLE, all reqs/busy/done/pass/timeout SHALL be 0, err_cnt 0, first_err_addr 0, and all counters 0.
REQ-042 Reset mid-burst SHALL abandon the run with no done pulse.
REQ-043 Address and data outputs SHALL reset to 0.

Verification
REQ-044 Ideal controller model, BURST=8, NUM_BURSTS=4, base 0, seed 16'hA5A5 -> 32 writes then 32 reads, done pulse, pass=1, err_cnt=0.
REQ-045 Model corrupts read word at address 24'h000013 -> err_cnt=1, first_err_addr=24'h000013, pass=0.
REQ-046 base_addr=24'hFFFFFC, BURST=8, NUM_BURSTS=1 -> addresses FFFFFC..FFFFFF then 000000..000003, pass=1.
REQ-047 Model never asserts rd_ack -> rd_req drops after 1023 cycles, timeout=1, pass=0, done pulses.
REQ-048 init_done held 0 for 500 cycles after start -> no req until init_done=1; start pulsed while busy -> no effect.
REQ-049 Model holds wr_ack 10 cycles for BURST=8, then assert rst mid-read -> 2 extra acks ignored; reset returns all outputs to 0 with no done pulse.

Source files
------------

// File: rtl/sdram_burst_tester.sv
// Writes NUM_BURSTS bursts of an address-derived pattern to the SDRAM controller,
// reads them back, and reports the mismatch count, first failing address and ack timeouts.
module sdram_burst_tester #(
  parameter int BURST      = 8,
  parameter int NUM_BURSTS = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [23:0] base_addr,
  input  logic        sdram_init_done,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_wr_addr,
  output logic [9:0]  sdram_wr_burst,
  output logic [15:0] sdram_din,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [23:0] sdram_rd_addr,
  output logic [9:0]  sdram_rd_burst,
  input  logic [15:0] sdram_dout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [23:0] first_err_addr
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_INIT = 3'd1;
  localparam logic [2:0] WR_REQ    = 3'd2;
  localparam logic [2:0] WR_DATA   = 3'd3;
  localparam logic [2:0] RD_REQ    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] FINISH    = 3'd6;

  localparam int         TMO_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [9:0]  LP_BURST      = 10'(BURST);
  localparam logic [15:0] LP_LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [23:0] LP_STEP       = 24'(BURST);

  logic [2:0]       r_state;
  logic [15:0]      r_seed;
  logic [23:0]      r_base;
  logic [23:0]      r_burst_addr;
  logic [15:0]      r_burst_idx;
  logic [9:0]       r_word_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [15:0]      r_err_cnt;
  logic [23:0]      r_first_err_addr;
  logic             r_wr_req;
  logic             r_rd_req;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  logic [23:0] w_word_addr;
  logic [15:0] w_pattern;
  logic        w_wr_hit;
  logic        w_rd_hit;
  logic        w_mismatch;
  logic        w_burst_full;
  logic        w_last_burst;

  function automatic logic [15:0] f_pattern(input logic [23:0] a, input logic [15:0] s);
    return a[15:0] ^ s ^ {a[23:16], a[23:16]};
  endfunction

  assign w_word_addr  = r_burst_addr + 24'(r_word_cnt);
  assign w_pattern    = f_pattern(w_word_addr, r_seed);
  assign w_burst_full = (r_word_cnt == LP_BURST);
  assign w_last_burst = (r_burst_idx == LP_LAST_BURST);
  // Acks past the burst length are dropped so the counter never overruns.
  assign w_wr_hit     = sdram_wr_ack && !w_burst_full;
  assign w_rd_hit     = sdram_rd_ack && !w_burst_full &&
                        (r_state == RD_REQ || r_state == RD_DATA);
  assign w_mismatch   = w_rd_hit && (sdram_dout != w_pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_seed           <= '0;
      r_base           <= '0;
      r_burst_addr     <= '0;
      r_burst_idx      <= '0;
      r_word_cnt       <= '0;
      r_tmo_cnt        <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_wr_req         <= 1'b0;
      r_rd_req         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)    r_first_err_addr <= w_word_addr;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_seed           <= seed;
            r_base           <= base_addr;
            r_burst_addr     <= base_addr;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_busy           <= 1'b1;
            r_state          <= WAIT_INIT;
          end
        end
        WAIT_INIT: begin
          if (sdram_init_done) begin
            r_burst_idx <= '0;
            r_word_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_wr_req    <= 1'b1;
            r_state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            r_word_cnt <= r_word_cnt + 10'd1;
            r_wr_req   <= 1'b0;
            r_state    <= WR_DATA;
          end else if (r_tmo_cnt == LP_TMO_LAST) begin
            r_wr_req  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= FINISH;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        WR_DATA: begin
          if (w_burst_full) begin
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            if (w_last_burst) begin
              r_burst_idx  <= '0;
              r_burst_addr <= r_base;
              r_rd_req     <= 1'b1;
              r_state      <= RD_REQ;
            end else begin
              r_burst_idx  <= r_burst_idx + 16'd1;
              r_burst_addr <= r_burst_addr + LP_STEP;
              r_wr_req     <= 1'b1;
              r_state      <= WR_REQ;
            end
          end else if (w_wr_hit) begin
            r_word_cnt <= r_word_cnt + 10'd1;
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            r_word_cnt <= r_word_cnt + 10'd1;
            r_rd_req   <= 1'b0;
            r_state    <= RD_DATA;
          end else if (r_tmo_cnt == LP_TMO_LAST) begin
            r_rd_req  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= FINISH;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (w_burst_full) begin
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            if (w_last_burst) begin
              r_state <= FINISH;
            end else begin
              r_burst_idx  <= r_burst_idx + 16'd1;
              r_burst_addr <= r_burst_addr + LP_STEP;
              r_rd_req     <= 1'b1;
              r_state      <= RD_REQ;
            end
          end else if (w_rd_hit) begin
            r_word_cnt <= r_word_cnt + 10'd1;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= !r_timeout && (r_err_cnt == 16'd0);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sdram_wr_req   = r_wr_req;
  assign sdram_rd_req   = r_rd_req;
  assign sdram_wr_addr  = r_burst_addr;
  assign sdram_rd_addr  = r_burst_addr;
  assign sdram_wr_burst = LP_BURST;
  assign sdram_rd_burst = LP_BURST;
  assign sdram_din      = w_pattern;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Directed bench for sdram_burst_tester with a behavioural SDRAM controller model
// that can delay, withhold, over-extend or corrupt acknowledged data.
module tb_sdram_burst_tester;

  localparam int BURST_P = 8;
  localparam int NB_P    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [23:0] base_addr = '0;
  logic        init_done = 1'b1;
  logic        wr_req, rd_req;
  logic        wr_ack, rd_ack;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst, rd_burst;
  logic [15:0] din, dout;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [23:0] first_err_addr;

  int assertions = 0;
  int failures   = 0;

  // model knobs, written only by the main sequence
  int          ack_delay   = 2;
  bit          no_rd_ack   = 1'b0;
  bit          corrupt_en  = 1'b0;
  logic [23:0] corrupt_addr = '0;
  bit          extra_en    = 1'b0;
  int          extra_idx   = 0;

  // model / monitor state, written only by their own processes
  logic [15:0] mem [logic [23:0]];
  logic [23:0] wr_burst_q[$];
  int wr_words = 0, rd_words = 0;
  int done_cnt = 0, overlap_cnt = 0, wr_req_cycles = 0;
  int rd_run = 0, rd_run_last = 0;

  always #5 clk = ~clk;

  sdram_burst_tester #(.BURST(BURST_P), .NUM_BURSTS(NB_P), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .base_addr(base_addr),
    .sdram_init_done(init_done),
    .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack), .sdram_wr_addr(wr_addr),
    .sdram_wr_burst(wr_burst), .sdram_din(din),
    .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack), .sdram_rd_addr(rd_addr),
    .sdram_rd_burst(rd_burst), .sdram_dout(dout),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  function automatic logic [15:0] pat(input logic [23:0] a, input logic [15:0] s);
    return a[15:0] ^ s ^ {a[23:16], a[23:16]};
  endfunction

  // Controller model: acts 1 time unit after each rising edge.
  initial begin
    int n;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    dout   = '0;
    forever begin
      @(posedge clk); #1;
      if (wr_req) begin
        wr_burst_q.push_back(wr_addr);
        repeat (ack_delay) begin @(posedge clk); #1; end
        n = BURST_P + ((extra_en && (wr_burst_q.size() - 1 == extra_idx)) ? 2 : 0);
        for (int k = 0; k < n; k++) begin
          wr_ack = 1'b1;
          if (k < BURST_P) begin
            mem[wr_addr + 24'(k)] = din;
            wr_words++;
          end
          @(posedge clk); #1;
        end
        wr_ack = 1'b0;
      end else if (rd_req && !no_rd_ack) begin
        repeat (ack_delay) begin @(posedge clk); #1; end
        for (int k = 0; k < BURST_P; k++) begin
          rd_ack = 1'b1;
          dout   = mem[rd_addr + 24'(k)];
          if (corrupt_en && (rd_addr + 24'(k) == corrupt_addr)) dout = dout ^ 16'h0001;
          rd_words++;
          @(posedge clk); #1;
        end
        rd_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_req && rd_req) overlap_cnt++;
    if (wr_req) wr_req_cycles++;
    if (rd_req) rd_run++;
    else if (rd_run != 0) begin
      rd_run_last = rd_run;
      rd_run = 0;
    end
  end

  task automatic pulse_start(input logic [23:0] b, input logic [15:0] s);
    @(negedge clk);
    base_addr = b;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertions++;
    if ({wr_req, rd_req, busy, done, pass, timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got %b want 000000", {wr_req, rd_req, busy, done, pass, timeout});
    end
    assertions++;
    if ({err_cnt, first_err_addr, wr_addr, rd_addr, din} !== '0) begin
      failures++;
      $display("FAIL reset_data err=%h fea=%h wa=%h ra=%h din=%h want all 0",
               err_cnt, first_err_addr, wr_addr, rd_addr, din);
    end
    assertions++;
    if (wr_burst !== 10'd8 || rd_burst !== 10'd8) begin
      failures++;
      $display("FAIL burst_len got wr=%0d rd=%0d want 8", wr_burst, rd_burst);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    bit ok;
    int d0 = done_cnt, w0 = wr_words, r0 = rd_words, o0 = overlap_cnt, bad = 0;
    pulse_start(24'h000000, 16'hA5A5);
    wait_done(ok);
    assertions++;
    if (!ok) begin failures++; $display("FAIL basic_done got none want pulse"); end
    assertions++;
    if (done_cnt - d0 != 1 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width got %0d pulses done=%b want 1 pulse", done_cnt - d0, done);
    end
    assertions++;
    if (wr_words - w0 != 32 || rd_words - r0 != 32) begin
      failures++;
      $display("FAIL basic_words got wr=%0d rd=%0d want 32/32", wr_words - w0, rd_words - r0);
    end
    for (int a = 0; a < 32; a++) if (mem[24'(a)] !== pat(24'(a), 16'hA5A5)) bad++;
    assertions++;
    if (bad != 0) begin failures++; $display("FAIL basic_data got %0d bad words want 0", bad); end
    assertions++;
    if ({pass, timeout, busy} !== 3'b100 || err_cnt !== 16'd0 || first_err_addr !== 24'd0) begin
      failures++;
      $display("FAIL basic_status got p=%b t=%b b=%b err=%0d fea=%h want 1 0 0 0 0",
               pass, timeout, busy, err_cnt, first_err_addr);
    end
    assertions++;
    if (overlap_cnt != o0) begin failures++; $display("FAIL req_overlap got %0d want 0", overlap_cnt - o0); end
    $display("test_basic done");
  endtask

  task automatic test_corrupt;
    bit ok;
    corrupt_en   = 1'b1;
    corrupt_addr = 24'h000013;
    pulse_start(24'h000000, 16'hA5A5);
    wait_done(ok);
    corrupt_en = 1'b0;
    assertions++;
    if (!ok || err_cnt !== 16'd1 || first_err_addr !== 24'h000013 || pass !== 1'b0) begin
      failures++;
      $display("FAIL corrupt done=%b err=%0d fea=%h pass=%b want 1 1 000013 0",
               ok, err_cnt, first_err_addr, pass);
    end
    $display("test_corrupt done");
  endtask

  task automatic test_wrap;
    bit ok;
    int q0 = wr_burst_q.size();
    pulse_start(24'hFFFFFC, 16'h1234);
    wait_done(ok);
    assertions++;
    if (!ok || pass !== 1'b1) begin failures++; $display("FAIL wrap_pass done=%b pass=%b want 1 1", ok, pass); end
    assertions++;
    if (wr_burst_q.size() < q0 + 2 || wr_burst_q[q0] !== 24'hFFFFFC || wr_burst_q[q0+1] !== 24'h000004) begin
      failures++;
      $display("FAIL wrap_addr got bursts=%0d want FFFFFC,000004", wr_burst_q.size() - q0);
    end
    assertions++;
    if (mem[24'hFFFFFF] !== pat(24'hFFFFFF, 16'h1234) || mem[24'h000000] !== pat(24'h000000, 16'h1234)) begin
      failures++;
      $display("FAIL wrap_data got %h %h want %h %h", mem[24'hFFFFFF], mem[24'h000000],
               pat(24'hFFFFFF, 16'h1234), pat(24'h000000, 16'h1234));
    end
    $display("test_wrap done");
  endtask

  task automatic test_timeout;
    bit ok;
    int d0 = done_cnt;
    no_rd_ack = 1'b1;
    pulse_start(24'h000000, 16'h0F0F);
    wait_done(ok);
    no_rd_ack = 1'b0;
    assertions++;
    if (!ok || timeout !== 1'b1 || pass !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL timeout_status done=%b t=%b p=%b pulses=%0d want 1 1 0 1", ok, timeout, pass, done_cnt - d0);
    end
    assertions++;
    if (rd_run_last != 1023) begin failures++; $display("FAIL timeout_len got %0d want 1023", rd_run_last); end
    $display("test_timeout done");
  endtask

  task automatic test_init_wait;
    bit ok;
    int q0 = wr_burst_q.size();
    int c0;
    init_done = 1'b0;
    pulse_start(24'h000040, 16'h0F0F);
    c0 = wr_req_cycles;
    repeat (250) @(negedge clk);
    pulse_start(24'h00AA00, 16'hFFFF);
    repeat (248) @(negedge clk);
    assertions++;
    if (wr_req_cycles != c0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL init_hold got req_cycles=%0d busy=%b want 0 1", wr_req_cycles - c0, busy);
    end
    init_done = 1'b1;
    repeat (30) @(negedge clk);
    init_done = 1'b0;
    wait_done(ok);
    init_done = 1'b1;
    assertions++;
    if (!ok || pass !== 1'b1) begin failures++; $display("FAIL init_run done=%b pass=%b want 1 1", ok, pass); end
    assertions++;
    if (wr_burst_q.size() <= q0 || wr_burst_q[q0] !== 24'h000040 || mem[24'h000040] !== pat(24'h000040, 16'h0F0F)) begin
      failures++;
      $display("FAIL restart_ignored got bursts=%0d data=%h want addr 000040 data %h",
               wr_burst_q.size() - q0, mem[24'h000040], pat(24'h000040, 16'h0F0F));
    end
    $display("test_init_wait done");
  endtask

  task automatic test_extra_ack;
    bit ok;
    int w0 = wr_words;
    extra_idx = wr_burst_q.size() + NB_P - 1;
    extra_en  = 1'b1;
    pulse_start(24'h000200, 16'h3C3C);
    wait_done(ok);
    extra_en = 1'b0;
    assertions++;
    if (!ok || pass !== 1'b1 || err_cnt !== 16'd0 || wr_words - w0 != 32) begin
      failures++;
      $display("FAIL extra_ack done=%b pass=%b err=%0d words=%0d want 1 1 0 32", ok, pass, err_cnt, wr_words - w0);
    end
    $display("test_extra_ack done");
  endtask

  task automatic test_reset_mid_read;
    bit seen = 1'b0;
    int d0;
    corrupt_en   = 1'b1;
    corrupt_addr = 24'h000101;
    pulse_start(24'h000100, 16'h5555);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (err_cnt != 16'd0) begin seen = 1'b1; break; end
    end
    assertions++;
    if (!seen || rd_addr !== 24'h000100) begin
      failures++;
      $display("FAIL midread_reach got seen=%b rd_addr=%h want 1 000100", seen, rd_addr);
    end
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    assertions++;
    if ({wr_req, rd_req, busy, done, pass, timeout} !== 6'b0 || err_cnt !== 16'd0 || first_err_addr !== 24'd0) begin
      failures++;
      $display("FAIL midread_reset got flags=%b err=%0d fea=%h want 0", {wr_req, rd_req, busy, done, pass, timeout},
               err_cnt, first_err_addr);
    end
    assertions++;
    if ({wr_addr, rd_addr, din} !== '0) begin
      failures++;
      $display("FAIL midread_outs got wa=%h ra=%h din=%h want 0", wr_addr, rd_addr, din);
    end
    @(negedge clk);
    rst = 1'b0;
    corrupt_en = 1'b0;
    repeat (20) @(negedge clk);
    assertions++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midread_nodone got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    $display("test_reset_mid_read done");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corrupt;
    test_wrap;
    test_timeout;
    test_init_wait;
    test_extra_ack;
    test_reset_mid_read;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
